add_arb: RTL and testbench

- Round-robin controller that shares one registered adder datapath among NREQ requesters.
- The adder has enable-gated input and output registers, so one result takes two `en` pulses: load, then capture.
- `add_arb` sits between requester logic and that adder. It selects a requester, drives the adder operands and `en`, and returns the registered sum/carry to the winner with a valid/ready handshake.
- The adder is instantiated externally, and its reset is driven from the same `rst`.

---
 rtl/add_arb_pkg.sv | 28 ++
 rtl/rr_arbiter.sv | 36 +++
 rtl/add_arb.sv | 164 ++++++++++++++++
 tb/tb_add_arb.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/add_arb_pkg.sv
// add_arb_pkg: shared types and helpers for the add_arb round-robin adder
// controller.
//   state_t   : controller FSM states (IDLE -> LOAD -> CAPT -> RESP)
//   clog2     : index width for a requester count (minimum 1 bit)
//   *_DEF     : default parameter values for NREQ / WIDTH
package add_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CAPT = 2'd2,
        RESP = 2'd3
    } state_t;

    localparam int NREQ_DEF  = 2;
    localparam int WIDTH_DEF = 8;

    // Bits needed to hold the values 0..n-1, never less than one.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: purely combinational round-robin pick.
// Ports:
//   req  in  NREQ  request vector
//   ptr  in  IW    highest-priority index for this pick
//   gnt  out NREQ  one-hot grant (all zero when req is zero)
//   idx  out IW    index of the granted line (0 when nothing granted)
module rr_arbiter
    import add_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int IW   = clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   idx
);

    // Walk the rotated order from lowest priority to highest so that the
    // last hit (the one nearest ptr) is the one that sticks.
    always_comb begin
        gnt = '0;
        idx = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            int c;
            c = int'(ptr) + i;
            if (c >= NREQ) c = c - NREQ;
            if (req[c]) begin
                gnt    = '0;
                gnt[c] = 1'b1;
                idx    = IW'(c);
            end
        end
    end

endmodule

// File: rtl/add_arb.sv
// add_arb: round-robin controller sharing one external registered adder
// (enable-gated input and output registers) among NREQ requesters.
// One transaction: IDLE (request accept) -> LOAD (adder inputs capture)
// -> CAPT (adder outputs capture) -> RESP (response handshake).
// Optional feature macro: ADD_ARB_TIMEOUT_EN -- bounds the RESP wait to
// TIMEOUT cycles, then discards the response and pulses rsp_drop.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   req_valid/req_ready      per-requester request handshake
//   req_a/req_b              packed operands, requester i at [i*WIDTH +: WIDTH]
//   req_ci                   per-requester carry-in
//   rsp_valid/rsp_ready      per-requester response handshake (one-hot valid)
//   rsp_sum/rsp_co           shared response sum / carry-out
//   rsp_drop                 one-cycle pulse on timeout discard (0 without macro)
//   add_a/add_b/add_ci/add_en  drive to the external adder
//   add_s/add_co             registered result from the external adder
module add_arb
    import add_arb_pkg::*;
#(
    parameter int NREQ    = NREQ_DEF,
    parameter int WIDTH   = WIDTH_DEF,
    parameter int TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    input  logic [NREQ-1:0]       req_ci,
    output logic [NREQ-1:0]       rsp_valid,
    input  logic [NREQ-1:0]       rsp_ready,
    output logic [WIDTH-1:0]      rsp_sum,
    output logic                  rsp_co,
    output logic                  rsp_drop,
    output logic [WIDTH-1:0]      add_a,
    output logic [WIDTH-1:0]      add_b,
    output logic                  add_ci,
    output logic                  add_en,
    input  logic [WIDTH-1:0]      add_s,
    input  logic                  add_co
);

    localparam int IW = clog2(NREQ);

    if (NREQ < 2 || NREQ > 8 || WIDTH < 1 || TIMEOUT < 1) begin : g_param_check
        $error("add_arb: parameter out of range");
    end

    state_t          state, state_nx;
    logic [IW-1:0]   ptr, grant;
    logic [WIDTH-1:0] a_p0, b_p0;
    logic            ci_p0;
    logic [NREQ-1:0] arb_gnt;
    logic [IW-1:0]   arb_idx;
    logic            take, done, timeout_hit;

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_arb (
        .req (req_valid),
        .ptr (ptr),
        .gnt (arb_gnt),
        .idx (arb_idx)
    );

    assign add_a  = a_p0;
    assign add_b  = b_p0;
    assign add_ci = ci_p0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        req_ready = '0;
        rsp_valid = '0;
        rsp_sum   = '0;
        rsp_co    = 1'b0;
        add_en    = 1'b0;
        take      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                // Ready is combinational from req_valid; held low while in reset.
                if (!rst) begin
                    req_ready = arb_gnt;
                    if (|arb_gnt) begin
                        take     = 1'b1;
                        state_nx = LOAD;
                    end
                end
            end
            LOAD: begin
                add_en   = 1'b1;
                state_nx = CAPT;
            end
            CAPT: begin
                add_en   = 1'b1;
                state_nx = RESP;
            end
            RESP: begin
                rsp_valid[grant] = 1'b1;
                rsp_sum          = add_s;
                rsp_co           = add_co;
                // A handshake on the limit cycle wins over the timeout.
                if (rsp_ready[grant] || timeout_hit) begin
                    done     = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Stage p0: request accept -> held operands / grant index
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr   <= '0;
            grant <= '0;
            a_p0  <= '0;
            b_p0  <= '0;
            ci_p0 <= 1'b0;
        end else begin
            if (take) begin
                grant <= arb_idx;
                a_p0  <= req_a[int'(arb_idx)*WIDTH +: WIDTH];
                b_p0  <= req_b[int'(arb_idx)*WIDTH +: WIDTH];
                ci_p0 <= req_ci[arb_idx];
            end
            if (done) begin
                ptr <= (grant == IW'(NREQ - 1)) ? '0 : grant + IW'(1);
            end
        end
    end

`ifdef ADD_ARB_TIMEOUT_EN
    localparam int CW = clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt;
    logic          drop_r;

    // cnt is 0 on the first RESP cycle; the limit is the TIMEOUT-th cycle.
    assign timeout_hit = (state == RESP) && (cnt == CW'(TIMEOUT - 1));
    assign rsp_drop    = drop_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            drop_r <= 1'b0;
        end else begin
            cnt    <= (state == RESP) ? cnt + CW'(1) : '0;
            drop_r <= timeout_hit && !rsp_ready[grant];
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign rsp_drop    = 1'b0;
`endif

endmodule

// File: tb/tb_add_arb.sv
// tb_add_arb: self-checking bench for add_arb (NREQ=2, WIDTH=8, TIMEOUT=15).
// Contains a behavioural model of the external two-register adder, a
// table of directed vectors, hand-written multi-cycle sequences and a
// randomized run checked against a rotation/arithmetic reference model.
// Timeout sequences are built only when ADD_ARB_TIMEOUT_EN is defined.
module tb_add_arb;

    localparam int NREQ    = 2;
    localparam int WIDTH   = 8;
    localparam int TIMEOUT = 15;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req_valid, req_ready;
    logic [NREQ*WIDTH-1:0] req_a, req_b;
    logic [NREQ-1:0]       req_ci;
    logic [NREQ-1:0]       rsp_valid, rsp_ready;
    logic [WIDTH-1:0]      rsp_sum;
    logic                  rsp_co, rsp_drop;
    logic [WIDTH-1:0]      add_a, add_b, add_s;
    logic                  add_ci, add_en, add_co;

    logic [WIDTH-1:0] op_a [NREQ];
    logic [WIDTH-1:0] op_b [NREQ];

    int n_chk  = 0;
    int n_fail = 0;
    int mptr   = 0;

    always #5 clk = ~clk;

    add_arb #(
        .NREQ    (NREQ),
        .WIDTH   (WIDTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ci    (req_ci),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_co    (rsp_co),
        .rsp_drop  (rsp_drop),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_ci    (add_ci),
        .add_en    (add_en),
        .add_s     (add_s),
        .add_co    (add_co)
    );

    always_comb begin
        req_a = '0;
        req_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*WIDTH +: WIDTH] = op_a[i];
            req_b[i*WIDTH +: WIDTH] = op_b[i];
        end
    end

    // External adder: enable-gated input registers feeding enable-gated
    // output registers, reset from the same rst.
    logic [WIDTH-1:0] ia, ib;
    logic             ic;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ia <= '0; ib <= '0; ic <= 1'b0;
            add_s <= '0; add_co <= 1'b0;
        end else if (add_en) begin
            ia <= add_a; ib <= add_b; ic <= add_ci;
            {add_co, add_s} <= {1'b0, ia} + {1'b0, ib} + {{WIDTH{1'b0}}, ic};
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, got running, required finished");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_winner(input logic [NREQ-1:0] v, input int p);
        for (int k = 0; k < NREQ; k++) begin
            if (v[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return 0;
    endfunction

    function automatic logic [WIDTH:0] ref_add(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic ci);
        return {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, ci};
    endfunction

    // Present vld in IDLE, expect the model's winner to get ready, finish on
    // the handshake edge (+1). Optionally drops all valids afterwards.
    task automatic grant_phase(input logic [NREQ-1:0] vld, input bit drop, output int w);
        int exp;
        int guard;
        exp = model_winner(vld, mptr);
        @(negedge clk);
        req_valid = vld;
        #1;
        guard = 0;
        while (req_ready == '0 && guard < 20) begin
            @(negedge clk);
            #1;
            guard++;
        end
        check("req_ready", 32'(req_ready), 32'(1) << exp);
        w = exp;
        @(posedge clk);
        #1;
        if (drop) req_valid = '0;
    endtask

    // Follow one transaction from the handshake edge to response acceptance.
    task automatic resp_phase(input int w, input int delay,
                              input logic [WIDTH-1:0] es, input logic eco);
        int lat;
        int en_cnt;
        logic [NREQ-1:0] oh;
        oh = NREQ'(1) << w;
        lat = 0;
        en_cnt = 0;
        do begin
            @(negedge clk);
            #1;
            lat++;
            if (add_en) en_cnt++;
        end while (rsp_valid == '0 && lat < 10);
        check("rsp_latency", lat, 3);
        check("add_en_cycles", en_cnt, 2);
        check("rsp_valid", 32'(rsp_valid), 32'(oh));
        check("rsp_sum", 32'(rsp_sum), 32'(es));
        check("rsp_co", 32'(rsp_co), 32'(eco));
        check("rsp_drop_idle", 32'(rsp_drop), 0);
        rsp_ready = ~oh;
        for (int k = 0; k < delay; k++) begin
            @(negedge clk);
            #1;
            check("hold_valid", 32'(rsp_valid), 32'(oh));
            check("hold_sum", 32'(rsp_sum), 32'(es));
            check("hold_co", 32'(rsp_co), 32'(eco));
            check("hold_no_req_ready", 32'(req_ready), 0);
            check("hold_no_drop", 32'(rsp_drop), 0);
        end
        rsp_ready = oh;
        @(posedge clk);
        #1;
        rsp_ready = '0;
        check("rsp_released", 32'(rsp_valid), 0);
        check("rsp_drop_after", 32'(rsp_drop), 0);
        mptr = (w + 1) % NREQ;
    endtask

    typedef struct {
        int               r;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             ci;
        logic [WIDTH-1:0] s;
        logic             co;
    } vec_t;

    vec_t tbl [7];

    initial begin
        int w;
        int cnt;
        logic [WIDTH:0] r9;

        tbl[0] = '{0, 8'h12, 8'h34, 1'b1, 8'h47, 1'b0};
        tbl[1] = '{0, 8'hFF, 8'h01, 1'b1, 8'h01, 1'b1};
        tbl[2] = '{1, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        tbl[3] = '{1, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
        tbl[4] = '{0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        tbl[5] = '{1, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        tbl[6] = '{0, 8'h7F, 8'h00, 1'b1, 8'h80, 1'b0};

        // Reset state, with requests pending to show ready is held off.
        rst       = 1'b1;
        req_valid = '1;
        rsp_ready = '0;
        req_ci    = '0;
        for (int i = 0; i < NREQ; i++) begin
            op_a[i] = 8'hA5;
            op_b[i] = 8'h5A;
        end
        #1;
        check("reset_req_ready", 32'(req_ready), 0);
        check("reset_rsp_valid", 32'(rsp_valid), 0);
        check("reset_add_en", 32'(add_en), 0);
        check("reset_add_a", 32'(add_a), 0);
        check("reset_add_b", 32'(add_b), 0);
        check("reset_add_ci", 32'(add_ci), 0);
        check("reset_rsp_drop", 32'(rsp_drop), 0);
        repeat (3) @(negedge clk);
        req_valid = '0;
        rst = 1'b0;
        mptr = 0;

        // Directed vectors.
        for (int n = 0; n < 7; n++) begin
            op_a[tbl[n].r]   = tbl[n].a;
            op_b[tbl[n].r]   = tbl[n].b;
            req_ci[tbl[n].r] = tbl[n].ci;
            grant_phase(NREQ'(1) << tbl[n].r, 1'b1, w);
            resp_phase(w, 0, tbl[n].s, tbl[n].co);
        end

        // Backpressure: 5 cycles of rsp_ready low while req1 waits.
        op_a[0] = 8'h3C; op_b[0] = 8'h0F; req_ci[0] = 1'b0;
        op_a[1] = 8'h01; op_b[1] = 8'h02; req_ci[1] = 1'b0;
        grant_phase(2'b01, 1'b1, w);
        req_valid = 2'b10;
        resp_phase(w, 5, 8'h4B, 1'b0);
        grant_phase(2'b11, 1'b1, w);
        check("bp_next_grant", w, 1);
        resp_phase(w, 0, 8'h03, 1'b0);

        // Asynchronous reset during CAPT.
        op_a[0] = 8'h11; op_b[0] = 8'h22; req_ci[0] = 1'b1;
        grant_phase(2'b01, 1'b1, w);
        @(negedge clk);
        @(negedge clk);
        #1;
        check("capt_add_en", 32'(add_en), 1);
        rst = 1'b1;
        #1;
        check("arst_rsp_valid", 32'(rsp_valid), 0);
        check("arst_add_en", 32'(add_en), 0);
        check("arst_add_a", 32'(add_a), 0);
        check("arst_add_b", 32'(add_b), 0);
        check("arst_add_ci", 32'(add_ci), 0);
        check("arst_req_ready", 32'(req_ready), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        mptr = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            check("arst_no_rsp", 32'(rsp_valid), 0);
        end
        op_a[1] = 8'h40; op_b[1] = 8'h02; req_ci[1] = 1'b1;
        grant_phase(2'b10, 1'b1, w);
        resp_phase(w, 0, 8'h43, 1'b0);

        // Round-robin with both held valid: grants 0,1,0,1.
        op_a[0] = 8'h10; op_b[0] = 8'h20; req_ci[0] = 1'b0;
        op_a[1] = 8'hF0; op_b[1] = 8'h15; req_ci[1] = 1'b1;
        for (int n = 0; n < 4; n++) begin
            grant_phase(2'b11, 1'b0, w);
            check("rr_grant", w, n % 2);
            r9 = ref_add(op_a[w], op_b[w], req_ci[w]);
            op_a[w] = op_a[w] + 8'h11;
            resp_phase(w, 0, r9[WIDTH-1:0], r9[WIDTH]);
        end
        req_valid = '0;

        // Randomized traffic against the reference model.
        for (int n = 0; n < 40; n++) begin
            logic [NREQ-1:0] v;
            v = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            for (int i = 0; i < NREQ; i++) begin
                op_a[i]   = WIDTH'($urandom);
                op_b[i]   = WIDTH'($urandom);
                req_ci[i] = 1'($urandom);
            end
            grant_phase(v, 1'b1, w);
            r9 = ref_add(op_a[w], op_b[w], req_ci[w]);
            resp_phase(w, $urandom_range(0, 3), r9[WIDTH-1:0], r9[WIDTH]);
        end

`ifdef ADD_ARB_TIMEOUT_EN
        // Handshake on the limit cycle is accepted.
        op_a[mptr] = 8'h05; op_b[mptr] = 8'h06; req_ci[mptr] = 1'b0;
        grant_phase(NREQ'(1) << mptr, 1'b1, w);
        resp_phase(w, TIMEOUT - 1, 8'h0B, 1'b0);

        // No acceptance: response dropped after TIMEOUT RESP cycles.
        mptr = 0;
        op_a[0] = 8'h09; op_b[0] = 8'h01; req_ci[0] = 1'b0;
        op_a[1] = 8'h20; op_b[1] = 8'h30; req_ci[1] = 1'b0;
        grant_phase(2'b01, 1'b1, w);
        cnt = 0;
        do begin
            @(negedge clk);
            #1;
            cnt++;
        end while (rsp_valid == '0 && cnt < 10);
        cnt = 0;
        while (rsp_valid[0] && cnt < 40) begin
            cnt++;
            @(negedge clk);
            #1;
        end
        check("to_resp_cycles", cnt, TIMEOUT);
        check("to_drop_pulse", 32'(rsp_drop), 1);
        check("to_valid_low", 32'(rsp_valid), 0);
        mptr = 1;
        grant_phase(2'b11, 1'b1, w);
        check("to_next_grant", w, 1);
        resp_phase(w, 0, 8'h50, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
